// File: rtl/mealy_pkg.sv
// rtl/mealy_pkg.sv - shared types and constants for the Mealy input conditioner
package mealy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_HI = 2'd1,
        HELD   = 2'd2,
        DEB_LO = 2'd3
    } cond_state_t;

    localparam int COUNT_W = 8;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/mealy_sync.sv
// rtl/mealy_sync.sv - N-stage asynchronous-reset synchroniser for one raw pin
// Ports:
//   clk    design clock
//   rst_n  asynchronous active-low reset, all stages clear to 0
//   d      raw asynchronous input
//   q      synchronised output (last stage)
module mealy_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Plain shift chain: nothing may sit between stages or the MTBF gain is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/mealy_input_conditioner.sv
// rtl/mealy_input_conditioner.sv - synchronise and debounce the bit-enter button into single-cycle bit strobes
// Optional build macro: MEALY_COND_GLITCH_CNT_EN (enables glitch_cnt; otherwise tied to 0)
// Ports:
//   clk         design clock
//   rst_n       asynchronous active-low reset
//   ena         design enable; low forces IDLE and suppresses strobes
//   din         raw serial data bit
//   stb         raw bouncy bit-enter button, active high
//   bit_valid   one-cycle strobe per accepted press
//   bit_data    value of din captured when the press was accepted
//   busy        debounce FSM is not in IDLE
//   bit_count   accepted-bit count, wraps
//   glitch_cnt  rejected-bounce count, saturating
module mealy_input_conditioner
    import mealy_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               din,
    input  logic               stb,
    output logic               bit_valid,
    output logic               bit_data,
    output logic               busy,
    output logic [COUNT_W-1:0] bit_count,
    output logic [COUNT_W-1:0] glitch_cnt
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic din_s;
    logic stb_s;

    mealy_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (din_s)
    );

    mealy_sync #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stb),
        .q     (stb_s)
    );

    cond_state_t      state;
    cond_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt is cleared on every state change so each debounce window starts fresh.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_accept = 1'b0;
        if (!ena) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stb_s) begin
                        state_next = DEB_HI;
                        cnt_next   = '0;
                    end
                end
                DEB_HI: begin
                    if (!stb_s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next   = HELD;
                        cnt_next     = '0;
                        press_accept = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!stb_s) begin
                        state_next = DEB_LO;
                        cnt_next   = '0;
                    end
                end
                DEB_LO: begin
                    // A short release returns to HELD without re-arming, so no second strobe.
                    if (stb_s) begin
                        state_next = HELD;
                        cnt_next   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are registered on the same edge the FSM enters HELD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
            busy      <= 1'b0;
            bit_count <= '0;
        end else begin
            bit_valid <= press_accept;
            busy      <= (state_next != IDLE);
            if (press_accept) begin
                bit_data  <= din_s;
                bit_count <= bit_count + 1'b1;
            end
        end
    end

`ifdef MEALY_COND_GLITCH_CNT_EN
    logic glitch_evt;

    assign glitch_evt = ena && (((state == DEB_HI) && !stb_s) ||
                                ((state == DEB_LO) &&  stb_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (glitch_evt && (glitch_cnt != COUNT_MAX)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_input_conditioner.sv
// tb/tb_mealy_input_conditioner.sv - self-checking bench for mealy_input_conditioner
module tb_mealy_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

`ifdef MEALY_COND_GLITCH_CNT_EN
    localparam bit GLITCH_ON = 1'b1;
`else
    localparam bit GLITCH_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       din;
    logic       stb;
    logic       bit_valid;
    logic       bit_data;
    logic       busy;
    logic [7:0] bit_count;
    logic [7:0] glitch_cnt;

    always #5 clk = ~clk;

    mealy_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .din        (din),
        .stb        (stb),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .busy       (busy),
        .bit_count  (bit_count),
        .glitch_cnt (glitch_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: the accepted button level flips once the synchronised
    // pin has disagreed with it for DEB+1 consecutive samples; an earlier
    // agreement is a rejected bounce.
    typedef struct {
        bit level;
        int run;
        bit valid;
        bit data;
        int count;
        int glitch;
        bit busy;
    } model_t;

    function automatic model_t step(model_t m, bit en, bit s, bit d);
        model_t n = m;
        n.valid = 1'b0;
        if (!en) begin
            n.level = 1'b0;
            n.run   = 0;
            n.busy  = 1'b0;
            return n;
        end
        if (s != m.level) begin
            n.run = m.run + 1;
            if (n.run == DEB + 1) begin
                n.level = s;
                n.run   = 0;
                if (s) begin
                    n.valid = 1'b1;
                    n.data  = d;
                    n.count = (m.count + 1) % 256;
                end
            end
        end else if (m.run > 0) begin
            n.run = 0;
            if (GLITCH_ON && m.glitch < 255) n.glitch = m.glitch + 1;
        end
        n.busy = n.level || (n.run > 0);
        return n;
    endfunction

    model_t        m;
    bit [SYNC-1:0] sp;
    bit [SYNC-1:0] dp;
    bit            mon_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m  <= '{default: 0};
            sp <= '0;
            dp <= '0;
        end else begin
            m  <= step(m, ena, sp[SYNC-1], dp[SYNC-1]);
            sp <= {sp[SYNC-2:0], stb};
            dp <= {dp[SYNC-2:0], din};
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("model bit_valid", int'(bit_valid), int'(m.valid));
            check("model busy", int'(busy), int'(m.busy));
            check("model bit_count", int'(bit_count), m.count);
            check("model glitch_cnt", int'(glitch_cnt), m.glitch);
            if (m.valid) check("model bit_data", int'(bit_data), int'(m.data));
        end
    end

    int strobes   = 0;
    bit last_data = 1'b0;

    always @(negedge clk) begin
        if (rst_n && bit_valid) begin
            strobes++;
            last_data = bit_data;
        end
    end

    task automatic drive(input bit level, input int n);
        stb = level;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        int hi;
        int lo;
        bit d;
        int exp_strobes;
        bit exp_data;
        int exp_glitch;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int g0;
        int c0;

        tbl[0] = '{hi: 20, lo: 20, d: 1'b1, exp_strobes: 1, exp_data: 1'b1, exp_glitch: 0};
        tbl[1] = '{hi: 2,  lo: 20, d: 1'b1, exp_strobes: 0, exp_data: 1'b0, exp_glitch: 1};
        tbl[2] = '{hi: 4,  lo: 20, d: 1'b0, exp_strobes: 0, exp_data: 1'b0, exp_glitch: 1};
        tbl[3] = '{hi: 5,  lo: 20, d: 1'b1, exp_strobes: 1, exp_data: 1'b1, exp_glitch: 0};
        tbl[4] = '{hi: 10, lo: 20, d: 1'b0, exp_strobes: 1, exp_data: 1'b0, exp_glitch: 0};

        rst_n = 1'b0;
        ena   = 1'b1;
        din   = 1'b0;
        stb   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset bit_valid", int'(bit_valid), 0);
        check("reset bit_data", int'(bit_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset bit_count", int'(bit_count), 0);
        check("reset glitch_cnt", int'(glitch_cnt), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press with latency measurement.
        strobes = 0;
        lat     = -1;
        din     = 1'b1;
        stb     = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bit_valid && lat < 0) begin
                lat = i;
                check("clean bit_data", int'(bit_data), 1);
            end
        end
        check("clean latency", lat, SYNC + DEB + 1);
        drive(1'b0, 20);
        check("clean strobes", strobes, 1);
        check("clean bit_count", int'(bit_count), 1);
        check("clean busy idle", int'(busy), 0);

        // Table-driven press patterns.
        for (int k = 0; k < 5; k++) begin
            g0      = int'(glitch_cnt);
            strobes = 0;
            din     = tbl[k].d;
            drive(1'b1, tbl[k].hi);
            drive(1'b0, tbl[k].lo);
            check($sformatf("tbl%0d strobes", k), strobes, tbl[k].exp_strobes);
            if (tbl[k].exp_strobes > 0)
                check($sformatf("tbl%0d bit_data", k), int'(last_data), int'(tbl[k].exp_data));
            check($sformatf("tbl%0d glitch delta", k), int'(glitch_cnt) - g0,
                  GLITCH_ON ? tbl[k].exp_glitch : 0);
            check($sformatf("tbl%0d busy", k), int'(busy), 0);
        end

        // Bounce reject: two short pulses.
        g0      = int'(glitch_cnt);
        strobes = 0;
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, 20);
        check("bounce strobes", strobes, 0);
        check("bounce glitch delta", int'(glitch_cnt) - g0, GLITCH_ON ? 2 : 0);

        // Release bounce: short release must not re-arm.
        g0      = int'(glitch_cnt);
        strobes = 0;
        drive(1'b1, 20);
        drive(1'b0, 2);
        drive(1'b1, 1);
        drive(1'b0, 10);
        drive(1'b0, 10);
        check("release strobes", strobes, 1);
        check("release glitch delta", int'(glitch_cnt) - g0, GLITCH_ON ? 1 : 0);

        // Data capture: din changes during DEB_HI, then again after the strobe.
        strobes = 0;
        din     = 1'b0;
        stb     = 1'b1;
        repeat (2) @(negedge clk);
        din = 1'b1;
        repeat (10) @(negedge clk);
        din = 1'b0;
        repeat (8) @(negedge clk);
        drive(1'b0, 20);
        check("capture strobes", strobes, 1);
        check("capture bit_data", int'(last_data), 1);

        // Enable dropped mid-DEB_HI.
        strobes = 0;
        c0      = int'(bit_count);
        g0      = int'(glitch_cnt);
        stb     = 1'b1;
        repeat (4) @(negedge clk);
        check("ena pre-drop busy", int'(busy), 1);
        ena = 1'b0;
        @(negedge clk);
        check("ena drop busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        drive(1'b0, 10);
        check("ena strobes", strobes, 0);
        check("ena bit_count held", int'(bit_count), c0);
        check("ena glitch held", int'(glitch_cnt), g0);
        ena = 1'b1;
        repeat (5) @(negedge clk);

        // Wrap: 256 presses from a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        strobes = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            din = k[0];
            drive(1'b1, 6);
            drive(1'b0, 8);
            if (k == 254) check("wrap count 255", int'(bit_count), 255);
        end
        check("wrap strobes", strobes, 256);
        check("wrap bit_count", int'(bit_count), 0);

        // Asynchronous reset while HELD.
        din = 1'b1;
        stb = 1'b1;
        repeat (10) @(negedge clk);
        check("held busy", int'(busy), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset bit_valid", int'(bit_valid), 0);
        check("areset bit_data", int'(bit_data), 0);
        check("areset busy", int'(busy), 0);
        check("areset bit_count", int'(bit_count), 0);
        check("areset glitch_cnt", int'(glitch_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        strobes = 0;
        repeat (15) @(negedge clk);
        check("areset fresh strobes", strobes, 1);
        drive(1'b0, 15);

        // Randomised bursts against the model.
        for (int k = 0; k < 80; k++) begin
            int len;
            len = $urandom_range(1, 9);
            stb = 1'($urandom_range(0, 1));
            ena = ($urandom_range(0, 19) != 0);
            for (int j = 0; j < len; j++) begin
                din = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        ena = 1'b1;
        drive(1'b0, 20);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mealy_input_conditioner.md
Name: mealy_input_conditioner

Overview:
Upstream front-end for the tt_um_dev_mealy sequence detector. Takes a raw serial data pin (`din`) and a raw, bouncy "bit-enter" pushbutton (`stb`) from `ui_in`. Synchronises both and debounces `stb` through a small FSM. Emits exactly one single-cycle `bit_valid` strobe with `bit_data` per clean press; this is the only bit stream the Mealy core consumes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchroniser on `din` and `stb`; legal values 2..3.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a press or a release; legal values 2..255.

Ports:
- clk  input  1  design clock (`clk`)
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; low forces IDLE, no strobes
- din  input  1  raw serial data bit (asynchronous)
- stb  input  1  raw bit-enter button, active high, bouncy (asynchronous)
- bit_valid  output  1  single-cycle strobe: one accepted bit
- bit_data  output  1  accepted bit value; meaningful only while `bit_valid`=1
- busy  output  1  high whenever the FSM is not in IDLE
- bit_count  output  8  count of accepted bits, wraps 255->0
- glitch_cnt  output  8  rejected-bounce count, saturating (optional feature)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`rst_n`). All outputs and state go to 0 and the FSM to IDLE. Synchroniser flops reset to 0.
- Synchroniser: `din_s` and `stb_s` are the outputs of SYNC_STAGES flops. No logic is placed between synchroniser stages.
- Debounce counter `cnt`:
  - width $clog2(DEBOUNCE_CYCLES+1);
  - cleared on every state entry;
  - increments by 1 each cycle the watched level holds.
- FSM states:
  - IDLE: `stb_s`=1 -> DEB_HI.
  - DEB_HI:
    - `stb_s`=0 -> IDLE (glitch event).
    - `cnt`==DEBOUNCE_CYCLES-1 with `stb_s`=1 -> HELD; `bit_valid`=1 on the next cycle.
  - HELD: `stb_s`=0 -> DEB_LO.
  - DEB_LO:
    - `stb_s`=1 -> HELD (glitch event; no new strobe).
    - `cnt`==DEBOUNCE_CYCLES-1 with `stb_s`=0 -> IDLE.
- Output strobe:
  - `bit_valid` and `bit_data` are registered.
  - `bit_data` = `din_s` sampled on the same edge the FSM enters HELD.
  - `bit_valid` is high for exactly one cycle per press.
- Latency: `stb` pin rise to `bit_valid` high = SYNC_STAGES + DEBOUNCE_CYCLES + 1 clock cycles.
- `bit_count` increments on the cycle `bit_valid` is asserted; wraps 255->0.
- `busy` is registered state decode: (state != IDLE).
- `ena`=0:
  - FSM returns to IDLE next edge; `cnt` is cleared.
  - `bit_valid` is forced 0 that edge.
  - `bit_count` and `glitch_cnt` are held.
  - Synchronisers keep running.
- Boundaries:
  - A press shorter than DEBOUNCE_CYCLES yields no strobe.
  - `stb` held high indefinitely yields one strobe only.
  - A release shorter than DEBOUNCE_CYCLES does not re-arm.
  - A `din` change during DEB_HI is allowed; only the value at HELD entry counts.
  - Async reset mid-DEB_HI aborts the press with no strobe.

Optional Feature:
- Macro: MEALY_COND_GLITCH_CNT_EN.
- Defined: `glitch_cnt` increments on each DEB_HI->IDLE and each DEB_LO->HELD transition. It saturates at 255, resets to 0, and holds while `ena`=0.
- Undefined: no counter logic is generated and `glitch_cnt` is tied to 8'h00. The port exists in both builds.

Decomposition:
- Package `mealy_pkg`:
  - state enum `cond_state_t` {IDLE, DEB_HI, HELD, DEB_LO}, 2 bits;
  - constant COUNT_W = 8;
  - default-parameter constants.
- Sub-module `mealy_sync`: parameterised N-stage async-reset synchroniser, instantiated once per raw input. The FSM, counters and output registers stay in the top block.

Test Plan:
All cases use SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
- Clean press: `din`=1, `stb` high for 20 cycles then low for 20 -> one `bit_valid` 7 cycles after the `stb` rise, `bit_data`=1, `bit_count`=1, `busy` returns 0.
- Bounce reject: `stb` pulses high 2 cycles, low 2, high 3, low -> no `bit_valid`; `glitch_cnt`=2 with macro defined, 0 without.
- Release bounce: a clean press, then `stb` low 2 cycles, high 1, low 10 -> exactly one strobe; `glitch_cnt`=1 (macro on).
- Data capture: `din` toggles 0->1 two cycles after the `stb` rise -> `bit_data`=1; `din` changing after the HELD strobe does not alter the captured bit.
- Wrap and enable: 256 clean presses -> `bit_count` returns to 0. Drop `ena` mid-DEB_HI -> no strobe, `busy`=0 next cycle, counts held.
- Async reset: assert `rst_n`=0 asynchronously mid-HELD -> all outputs 0 immediately. After release, `stb` still high -> a fresh debounce gives one strobe.
